// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM encoding, NOP word, opcode field and
// the main opcodes so the fetch stage, decoder and bench agree on them.
package mips_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] R_FORMAT = 6'd0;
  localparam logic [OPCODE_W-1:0] LW       = 6'd35;
  localparam logic [OPCODE_W-1:0] SW       = 6'd43;
  localparam logic [OPCODE_W-1:0] BEQ      = 6'd4;
  localparam logic [OPCODE_W-1:0] ADDI     = 6'd8;

  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [31:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: instructions delivered and acks/instructions thrown away.
// Only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_fetched,
  input  logic        inc_killed,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_killed
);

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_killed  <= '0;
    end else begin
      if (inc_fetched) perf_fetched <= perf_fetched + 32'd1;
      if (inc_killed)  perf_killed  <= perf_killed + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem over req/ack, holds one instruction
// for the decoder. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_target,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [5:0]          opcode,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic [ADDR_W-1:0]   pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_killed
`endif
);

  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              kill_q;

  logic [ADDR_W-1:0] target;
  logic              ack_in_req;
  logic              ack_discard;
  logic              ack_load;
  logic              hold_flush;

  assign target      = redirect_target & ALIGN_MASK;
  assign ack_in_req  = (state_q == StReq) && imem_ack;
  // An ack is thrown away if it belongs to a killed transaction or races a redirect.
  assign ack_discard = ack_in_req && (kill_q || redirect_valid);
  assign ack_load    = ack_in_req && !ack_discard;
  assign hold_flush  = (state_q == StHold) && redirect_valid;

  // instr is forced to NOP whenever invalid, so the opcode needs no extra gating.
  assign opcode = get_opcode(instr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= '0;
      pc_plus4    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q  <= StReq;
          imem_req <= 1'b1;
          if (redirect_valid) begin
            pc_q      <= target;
            imem_addr <= target;
          end else begin
            imem_addr <= pc_q;
          end
        end

        StReq: begin
          if (redirect_valid) begin
            pc_q <= target;
            if (imem_ack) begin
              // Transaction already finished: reissue straight to the target.
              imem_addr <= target;
              kill_q    <= 1'b0;
            end else begin
              // Address must stay stable until the pending ack arrives.
              kill_q <= 1'b1;
            end
          end else if (ack_discard) begin
            kill_q    <= 1'b0;
            imem_addr <= pc_q;
          end else if (ack_load) begin
            instr       <= imem_rdata;
            instr_pc    <= imem_addr;
            pc_plus4    <= imem_addr + WORD_BYTES;
            instr_valid <= 1'b1;
            pc_q        <= imem_addr + WORD_BYTES;
            imem_req    <= 1'b0;
            state_q     <= StHold;
          end
        end

        StHold: begin
          if (hold_flush || !stall) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            instr_pc    <= '0;
            pc_plus4    <= '0;
            imem_req    <= 1'b1;
            state_q     <= StReq;
            if (hold_flush) begin
              pc_q      <= target;
              imem_addr <= target;
            end else begin
              imem_addr <= pc_q;
            end
          end
        end

        default: begin
          state_q  <= StIdle;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf_cnt (
    .clk          (clk),
    .reset        (reset),
    .inc_fetched  (ack_load),
    .inc_killed   (ack_discard || hold_flush),
    .perf_fetched (perf_fetched),
    .perf_killed  (perf_killed)
  );
`endif

endmodule
